// File: rtl/seg_share_pkg.sv
// Shared definitions for the seven-segment display sharing logic.
//   state_e     : display owner / FSM state; the encoding is also the cur_src code
//   BLANK_CODE_DEF, SEP_CODE : nibble codes understood by the scan driver
//   DIG_*_LSB   : low bit of each BCD digit inside the packed display word
//   next_mode() : mode-button rotation, digit_lsb() : digit index -> nibble LSB
package seg_share_pkg;

  typedef enum logic [1:0] {
    S_CLK   = 2'd0,
    S_SW    = 2'd1,
    S_SET   = 2'd2,
    S_ALARM = 2'd3
  } state_e;

  localparam logic [3:0] BLANK_CODE_DEF = 4'hE;
  localparam logic [3:0] SEP_CODE       = 4'hF;

  // Packed word layout {H1,H0,F,M1,M0,F,S1,S0}
  localparam int unsigned DIG_S0_LSB = 0;
  localparam int unsigned DIG_S1_LSB = 4;
  localparam int unsigned DIG_M0_LSB = 12;
  localparam int unsigned DIG_M1_LSB = 16;
  localparam int unsigned DIG_H0_LSB = 24;
  localparam int unsigned DIG_H1_LSB = 28;
  localparam int unsigned NUM_DIGITS = 6;

  // Digit index follows edit_pos bit order: 0=S0 .. 5=H1
  function automatic int unsigned digit_lsb(input int unsigned idx);
    case (idx)
      0:       digit_lsb = DIG_S0_LSB;
      1:       digit_lsb = DIG_S1_LSB;
      2:       digit_lsb = DIG_M0_LSB;
      3:       digit_lsb = DIG_M1_LSB;
      4:       digit_lsb = DIG_H0_LSB;
      default: digit_lsb = DIG_H1_LSB;
    endcase
  endfunction

  // Mode button rotation; the alarm screen is not part of the rotation
  function automatic state_e next_mode(input state_e s);
    case (s)
      S_CLK:   next_mode = S_SW;
      S_SW:    next_mode = S_SET;
      S_SET:   next_mode = S_CLK;
      default: next_mode = s;
    endcase
  endfunction

endpackage

// File: rtl/seg_share_ctrl_blink_gen.sv
// Free-running blink phase generator, shared by the edit screens.
//   clk, rst (async, active-low)
//   blink_phase : toggles every BLINK_HALF clk cycles (0 out of reset)
module blink_gen #(
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic blink_phase
);

  localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign blink_phase = phase_q;

endmodule

// File: rtl/seg_share_ctrl.sv
// Arbiter for the shared 8-digit seven-segment display word.
// Chooses clock time, stopwatch or set-mode word, lets an alarm pre-empt the
// display for ALARM_HOLD seconds (or until acknowledged) and blinks digits.
//   clk, rst (async, active-low)
//   mode_pulse         : one-cycle mode button edge, rotates CLK->SW->SET->CLK
//   src0/1/2_data[31:0]: clock / stopwatch / set-mode packed BCD words
//   edit_pos[5:0]      : one-hot digit being edited in set mode
//   alarm_req          : level alarm request (rising edge enters alarm)
//   alarm_ack          : one-cycle alarm acknowledge
//   disp_data[31:0]    : registered display word
//   cur_src[1:0]       : current owner (state encoding)
//   alarm_active       : high while in the alarm state
module seg_share_ctrl
  import seg_share_pkg::*;
#(
  parameter int unsigned BLINK_HALF  = 25_000_000,
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned ALARM_HOLD  = 10,
  parameter logic [3:0]  BLANK_CODE  = BLANK_CODE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_pulse,
  input  logic [31:0] src0_data,
  input  logic [31:0] src1_data,
  input  logic [31:0] src2_data,
  input  logic [5:0]  edit_pos,
  input  logic        alarm_req,
  input  logic        alarm_ack,
  output logic [31:0] disp_data,
  output logic [1:0]  cur_src,
  output logic        alarm_active
);

  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICK_CYCLES - 1);
  localparam logic [5:0]        HOLD_LAST = 6'(ALARM_HOLD - 1);

  state_e             state_q, state_d;
  state_e             saved_q, saved_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [5:0]         hold_q, hold_d;
  logic               alarm_req_q;
  logic [31:0]        disp_q, disp_d;
  logic [1:0]         cur_src_q;
  logic               alarm_active_q;

  logic blink_phase;
  logic alarm_edge;
  logic tick_wrap;
  logic edit_onehot;

  blink_gen #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk         (clk),
    .rst         (rst),
    .blink_phase (blink_phase)
  );

  assign alarm_edge  = alarm_req & ~alarm_req_q;
  assign tick_wrap   = (tick_q == TICK_MAX);
  assign edit_onehot = (edit_pos != 6'd0) && ((edit_pos & (edit_pos - 6'd1)) == 6'd0);

  // Next-state and alarm hold timing
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    tick_d  = tick_q;
    hold_d  = hold_q;
    if (state_q == S_ALARM) begin
      // Leave on the tick that would bring the hold count to ALARM_HOLD, so
      // the alarm is shown for exactly ALARM_HOLD*TICK_CYCLES cycles.
      // An ack outranks a simultaneous re-trigger edge.
      if (alarm_ack || (tick_wrap && hold_q == HOLD_LAST)) begin
        state_d = saved_q;
        tick_d  = '0;
        hold_d  = '0;
      end else if (alarm_edge) begin
        tick_d  = '0;
        hold_d  = '0;
      end else if (tick_wrap) begin
        tick_d  = '0;
        hold_d  = hold_q + 6'd1;
      end else begin
        tick_d  = tick_q + 1'b1;
      end
    end else if (alarm_edge) begin
      // Alarm outranks a coincident mode press; remember the pre-press owner
      saved_d = state_q;
      state_d = S_ALARM;
      tick_d  = '0;
      hold_d  = '0;
    end else if (mode_pulse) begin
      state_d = next_mode(state_q);
    end
  end

  // Display word selection, driven from the current (not next) state
  always_comb begin
    disp_d = src0_data;
    case (state_q)
      S_CLK: disp_d = src0_data;
      S_SW:  disp_d = src1_data;
      S_SET: begin
        disp_d = src2_data;
        if (blink_phase && edit_onehot) begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (edit_pos[i]) disp_d[digit_lsb(i) +: 4] = BLANK_CODE;
          end
        end
      end
      default: begin
        disp_d = src0_data;
        if (blink_phase) begin
          // Separator nibbles stay lit while every digit blinks
          for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            disp_d[digit_lsb(i) +: 4] = BLANK_CODE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_CLK;
      saved_q        <= S_CLK;
      tick_q         <= '0;
      hold_q         <= '0;
      alarm_req_q    <= 1'b0;
      disp_q         <= 32'h0000_0000;
      cur_src_q      <= 2'd0;
      alarm_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      saved_q        <= saved_d;
      tick_q         <= tick_d;
      hold_q         <= hold_d;
      alarm_req_q    <= alarm_req;
      disp_q         <= disp_d;
      cur_src_q      <= state_d;
      alarm_active_q <= (state_d == S_ALARM);
    end
  end

  assign disp_data    = disp_q;
  assign cur_src      = cur_src_q;
  assign alarm_active = alarm_active_q;

endmodule

// File: tb/tb_seg_share_ctrl.sv
module tb_seg_share_ctrl;

  localparam int unsigned BH = 4;
  localparam logic [31:0] SRC0     = 32'h12F3_4F56;
  localparam logic [31:0] SRC0_BLK = 32'hEEFE_EFEE;
  localparam logic [31:0] SRC1     = 32'h00F0_1F23;
  localparam logic [31:0] SRC2     = 32'h23F5_9F59;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_pulse;
  logic [31:0] src0_data, src1_data, src2_data;
  logic [5:0]  edit_pos;
  logic        alarm_req, alarm_ack;
  logic [31:0] disp_data;
  logic [1:0]  cur_src;
  logic        alarm_active;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned edges;

  logic [5:0]  pos_tbl [6];
  logic [31:0] blk_tbl [6];

  seg_share_ctrl #(
    .BLINK_HALF  (BH),
    .TICK_CYCLES (10),
    .ALARM_HOLD  (3),
    .BLANK_CODE  (4'hE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode_pulse   (mode_pulse),
    .src0_data    (src0_data),
    .src1_data    (src1_data),
    .src2_data    (src2_data),
    .edit_pos     (edit_pos),
    .alarm_req    (alarm_req),
    .alarm_ack    (alarm_ack),
    .disp_data    (disp_data),
    .cur_src      (cur_src),
    .alarm_active (alarm_active)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; the blink phase is derived from it
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  // Blink phase in effect at the edge that produced the current disp_data
  function automatic bit exp_phase();
    return (((edges - 1) / BH) % 2) == 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    mode_pulse = 1'b1;
    step();
    mode_pulse = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_cmp++; if (disp_data !== 32'h0) begin n_bad++; $display("FAIL reset_disp: got %h want %h", disp_data, 32'h0); end
    n_cmp++; if (cur_src !== 2'd0) begin n_bad++; $display("FAIL reset_cur_src: got %0d want 0", cur_src); end
    n_cmp++; if (alarm_active !== 1'b0) begin n_bad++; $display("FAIL reset_alarm_active: got %b want 0", alarm_active); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mode_cycle();
    step();
    n_cmp++; if (cur_src !== 2'd0) begin n_bad++; $display("FAIL mode_clk_src: got %0d want 0", cur_src); end
    n_cmp++; if (disp_data !== SRC0) begin n_bad++; $display("FAIL mode_clk_disp: got %h want %h", disp_data, SRC0); end
    pulse_mode();
    n_cmp++; if (cur_src !== 2'd1) begin n_bad++; $display("FAIL mode_sw_src: got %0d want 1", cur_src); end
    step();
    n_cmp++; if (disp_data !== SRC1) begin n_bad++; $display("FAIL mode_sw_disp: got %h want %h", disp_data, SRC1); end
    pulse_mode();
    n_cmp++; if (cur_src !== 2'd2) begin n_bad++; $display("FAIL mode_set_src: got %0d want 2", cur_src); end
    step();
    n_cmp++; if (disp_data !== SRC2) begin n_bad++; $display("FAIL mode_set_disp: got %h want %h", disp_data, SRC2); end
    pulse_mode();
    n_cmp++; if (cur_src !== 2'd0) begin n_bad++; $display("FAIL mode_wrap_src: got %0d want 0", cur_src); end
    step();
    n_cmp++; if (disp_data !== SRC0) begin n_bad++; $display("FAIL mode_wrap_disp: got %h want %h", disp_data, SRC0); end
  endtask

  task automatic test_set_blink();
    logic [31:0] exp;
    pulse_mode();
    pulse_mode();
    for (int t = 0; t < 6; t++) begin
      edit_pos = pos_tbl[t];
      for (int k = 0; k < 2 * BH; k++) begin
        step();
        exp = exp_phase() ? blk_tbl[t] : SRC2;
        n_cmp++;
        if (disp_data !== exp) begin
          n_bad++;
          $display("FAIL set_blink pos=%b k=%0d: got %h want %h", pos_tbl[t], k, disp_data, exp);
        end
      end
    end
    edit_pos = 6'd0;
    pulse_mode();
    n_cmp++; if (cur_src !== 2'd0) begin n_bad++; $display("FAIL set_exit_src: got %0d want 0", cur_src); end
  endtask

  task automatic test_alarm_timeout();
    logic [31:0] exp;
    pulse_mode();
    alarm_req = 1'b1;
    step();
    n_cmp++; if (cur_src !== 2'd3) begin n_bad++; $display("FAIL to_entry_src: got %0d want 3", cur_src); end
    n_cmp++; if (alarm_active !== 1'b1) begin n_bad++; $display("FAIL to_entry_active: got %b want 1", alarm_active); end
    for (int i = 1; i <= 29; i++) begin
      step();
      exp = exp_phase() ? SRC0_BLK : SRC0;
      n_cmp++; if (disp_data !== exp) begin n_bad++; $display("FAIL to_alarm_disp i=%0d: got %h want %h", i, disp_data, exp); end
      if (i == 29) begin
        n_cmp++; if (cur_src !== 2'd3) begin n_bad++; $display("FAIL to_hold29_src: got %0d want 3", cur_src); end
      end
    end
    step();
    n_cmp++; if (cur_src !== 2'd1) begin n_bad++; $display("FAIL to_exit_src: got %0d want 1", cur_src); end
    n_cmp++; if (alarm_active !== 1'b0) begin n_bad++; $display("FAIL to_exit_active: got %b want 0", alarm_active); end
    repeat (3) step();
    n_cmp++; if (cur_src !== 2'd1) begin n_bad++; $display("FAIL to_no_reentry: got %0d want 1", cur_src); end
    alarm_req = 1'b0;
    step();
  endtask

  task automatic test_alarm_ack();
    alarm_req = 1'b1;
    step();
    n_cmp++; if (cur_src !== 2'd3) begin n_bad++; $display("FAIL ack_entry_src: got %0d want 3", cur_src); end
    repeat (4) step();
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    n_cmp++; if (cur_src !== 2'd1) begin n_bad++; $display("FAIL ack_exit_src: got %0d want 1", cur_src); end
    n_cmp++; if (alarm_active !== 1'b0) begin n_bad++; $display("FAIL ack_exit_active: got %b want 0", alarm_active); end
    repeat (4) step();
    n_cmp++; if (cur_src !== 2'd1) begin n_bad++; $display("FAIL ack_level_held: got %0d want 1", cur_src); end
    alarm_req = 1'b0;
    step();
    alarm_req = 1'b1;
    step();
    n_cmp++; if (cur_src !== 2'd3) begin n_bad++; $display("FAIL ack_reentry_src: got %0d want 3", cur_src); end
    // Acknowledge and a fresh edge together: acknowledge wins
    alarm_req = 1'b0;
    step();
    alarm_req = 1'b1;
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    n_cmp++; if (cur_src !== 2'd1) begin n_bad++; $display("FAIL ack_vs_edge_src: got %0d want 1", cur_src); end
    step();
    n_cmp++; if (cur_src !== 2'd1) begin n_bad++; $display("FAIL ack_edge_dropped: got %0d want 1", cur_src); end
    alarm_req = 1'b0;
    step();
  endtask

  task automatic test_alarm_retrigger();
    alarm_req = 1'b1;
    step();
    repeat (8) step();
    alarm_req = 1'b0;
    step();
    alarm_req = 1'b1;
    step();
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 20) begin
        n_cmp++; if (cur_src !== 2'd3) begin n_bad++; $display("FAIL retrig_hold20_src: got %0d want 3", cur_src); end
      end
      if (i == 29) begin
        n_cmp++; if (cur_src !== 2'd3) begin n_bad++; $display("FAIL retrig_hold29_src: got %0d want 3", cur_src); end
      end
    end
    n_cmp++; if (cur_src !== 2'd1) begin n_bad++; $display("FAIL retrig_exit_src: got %0d want 1", cur_src); end
    alarm_req = 1'b0;
    step();
  endtask

  task automatic test_mode_and_alarm();
    pulse_mode();
    pulse_mode();
    n_cmp++; if (cur_src !== 2'd0) begin n_bad++; $display("FAIL ma_start_src: got %0d want 0", cur_src); end
    mode_pulse = 1'b1;
    alarm_req  = 1'b1;
    step();
    mode_pulse = 1'b0;
    n_cmp++; if (cur_src !== 2'd3) begin n_bad++; $display("FAIL ma_alarm_src: got %0d want 3", cur_src); end
    pulse_mode();
    n_cmp++; if (cur_src !== 2'd3) begin n_bad++; $display("FAIL ma_mode_ignored: got %0d want 3", cur_src); end
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    n_cmp++; if (cur_src !== 2'd0) begin n_bad++; $display("FAIL ma_return_src: got %0d want 0", cur_src); end
    alarm_req = 1'b0;
    step();
  endtask

  task automatic test_reset_in_alarm();
    bit found = 1'b0;
    alarm_req = 1'b1;
    step();
    n_cmp++; if (cur_src !== 2'd3) begin n_bad++; $display("FAIL ra_entry_src: got %0d want 3", cur_src); end
    for (int k = 0; k < 3 * BH; k++) begin
      step();
      if (exp_phase()) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL ra_blink_wait: got no blink phase want phase 1"); end
    n_cmp++; if (disp_data !== SRC0_BLK) begin n_bad++; $display("FAIL ra_blank_disp: got %h want %h", disp_data, SRC0_BLK); end
    rst = 1'b0;
    #1;
    n_cmp++; if (disp_data !== 32'h0) begin n_bad++; $display("FAIL ra_rst_disp: got %h want 0", disp_data); end
    n_cmp++; if (cur_src !== 2'd0) begin n_bad++; $display("FAIL ra_rst_src: got %0d want 0", cur_src); end
    n_cmp++; if (alarm_active !== 1'b0) begin n_bad++; $display("FAIL ra_rst_active: got %b want 0", alarm_active); end
    alarm_req = 1'b0;
    #2;
    rst = 1'b1;
    step();
    n_cmp++; if (cur_src !== 2'd0) begin n_bad++; $display("FAIL ra_post_src: got %0d want 0", cur_src); end
    n_cmp++; if (alarm_active !== 1'b0) begin n_bad++; $display("FAIL ra_post_active: got %b want 0", alarm_active); end
    n_cmp++; if (disp_data !== SRC0) begin n_bad++; $display("FAIL ra_post_disp: got %h want %h", disp_data, SRC0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pos_tbl[0] = 6'b000100; blk_tbl[0] = 32'h23F5_EF59;
    pos_tbl[1] = 6'b000001; blk_tbl[1] = 32'h23F5_9F5E;
    pos_tbl[2] = 6'b100000; blk_tbl[2] = 32'hE3F5_9F59;
    pos_tbl[3] = 6'b010000; blk_tbl[3] = 32'h2EF5_9F59;
    pos_tbl[4] = 6'b000101; blk_tbl[4] = 32'h23F5_9F59;
    pos_tbl[5] = 6'b000000; blk_tbl[5] = 32'h23F5_9F59;
    rst        = 1'b0;
    mode_pulse = 1'b0;
    alarm_req  = 1'b0;
    alarm_ack  = 1'b0;
    edit_pos   = 6'd0;
    src0_data  = SRC0;
    src1_data  = SRC1;
    src2_data  = SRC2;

    test_reset();
    test_mode_cycle();
    test_set_blink();
    test_alarm_timeout();
    test_alarm_ack();
    test_alarm_retrigger();
    test_mode_and_alarm();
    test_reset_in_alarm();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
